// File: rtl/muxn_arb.sv
// muxn_arb: N-channel valid/ready multiplexer with a single registered output
// slot. Channel choice is either a direct index (mode 0) or a round-robin
// search starting at a rotating pointer (mode 1).
module muxn_arb #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src,
  output logic                    err_sel
);

  // Output slot and arbitration state
  logic [WIDTH-1:0]  data_p1;
  logic [SEL_W-1:0]  src_p1;
  logic              vld_p1;
  logic              err_p1;
  logic [SEL_W-1:0]  ptr;

  logic              load;
  logic              sel_ok;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  grant;
  logic [NUM_IN-1:0] ready;
  logic              xfer;
  int                cand;

  // Advance a channel index by one, wrapping from NUM_IN-1 back to 0.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    if (int'(i) == NUM_IN - 1) return '0;
    return i + 1'b1;
  endfunction

  assign load = !vld_p1 || out_ready;

  // Only non-power-of-two channel counts can see an out-of-range select.
  generate
    if ((2 ** SEL_W) > NUM_IN) begin : g_sel_chk
      assign sel_ok = (sel < SEL_W'(NUM_IN));
    end else begin : g_sel_full
      assign sel_ok = 1'b1;
    end
  endgenerate

  // Round-robin search: first valid channel at ptr, ptr+1, ... modulo NUM_IN.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = (int'(ptr) + k) % NUM_IN;
      if (!rr_hit && in_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(cand);
      end
    end
  end

  // Accept decode; depends only on mode, sel, in_valid, ptr, load and rst.
  always_comb begin
    ready = '0;
    grant = '0;
    if (!rst) begin
      if (mode) begin
        grant = rr_idx;
        if (rr_hit) ready[rr_idx] = load;
      end else if (sel_ok) begin
        grant      = sel;
        ready[sel] = load && in_valid[sel];
      end
    end
  end

  assign xfer = |(in_valid & ready);

  // Output slot: load on transfer, drain on downstream accept, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      err_p1  <= 1'b0;
      ptr     <= '0;
    end else begin
      err_p1 <= !mode && !sel_ok;
      if (xfer) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_data[int'(grant)*WIDTH +: WIDTH];
        src_p1  <= grant;
        if (mode) ptr <= next_idx(grant);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign in_ready  = ready;
  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_src   = src_p1;
  assign err_sel   = err_p1;

endmodule

// File: tb/tb_muxn_arb.sv
// Bench for muxn_arb: a 4-channel and a 3-channel instance share stimulus and
// are compared every cycle against a behavioural model of the output slot.
module tb_muxn_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready_a;
  logic [15:0] out_data_a;
  logic        out_valid_a;
  logic [1:0]  out_src_a;
  logic        err_sel_a;

  logic [2:0]  in_ready_b;
  logic [15:0] out_data_b;
  logic        out_valid_b;
  logic [1:0]  out_src_b;
  logic        err_sel_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muxn_arb #(.WIDTH(16), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_src(out_src_a), .err_sel(err_sel_a)
  );

  muxn_arb #(.WIDTH(16), .NUM_IN(3)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data[47:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_src(out_src_b), .err_sel(err_sel_b)
  );

  // Model state, index 0 = 4-channel instance, 1 = 3-channel instance
  int          nin [2] = '{4, 3};
  int          m_vld [2];
  int          m_src [2];
  int          m_ptr [2];
  int          m_err [2];
  logic [15:0] m_data [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Which channel may hand over a word this cycle (one-hot, or 0).
  function automatic int exp_ready(input int j);
    int n;
    int c;
    n = nin[j];
    if (rst) return 0;
    if (m_vld[j] != 0 && !out_ready) return 0;
    if (!mode) begin
      if (int'(sel) < n && in_valid[sel]) return 1 << sel;
      return 0;
    end
    for (int k = 0; k < n; k++) begin
      c = (m_ptr[j] + k) % n;
      if (in_valid[c]) return 1 << c;
    end
    return 0;
  endfunction

  task automatic model_step();
    int r [2];
    int gi;
    for (int j = 0; j < 2; j++) r[j] = exp_ready(j);
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        m_vld[j] = 0; m_src[j] = 0; m_ptr[j] = 0; m_err[j] = 0; m_data[j] = '0;
      end else begin
        m_err[j] = (!mode && int'(sel) >= nin[j]) ? 1 : 0;
        if (r[j] != 0) begin
          gi = $clog2(r[j]);
          m_vld[j]  = 1;
          m_src[j]  = gi;
          m_data[j] = in_data[gi*16 +: 16];
          if (mode) m_ptr[j] = (gi + 1) % nin[j];
        end else if (out_ready) begin
          m_vld[j] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    chk("a_in_ready",  int'(in_ready_a),  exp_ready(0));
    chk("a_out_valid", int'(out_valid_a), m_vld[0]);
    chk("a_out_data",  int'(out_data_a),  int'(m_data[0]));
    chk("a_out_src",   int'(out_src_a),   m_src[0]);
    chk("a_err_sel",   int'(err_sel_a),   m_err[0]);
    chk("b_in_ready",  int'(in_ready_b),  exp_ready(1));
    chk("b_out_valid", int'(out_valid_b), m_vld[1]);
    chk("b_out_data",  int'(out_data_b),  int'(m_data[1]));
    chk("b_out_src",   int'(out_src_b),   m_src[1]);
    chk("b_err_sel",   int'(err_sel_b),   m_err[1]);
  endtask

  // Called ~1 time unit after a rising edge with inputs already applied.
  task automatic step();
    #2;
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      m_vld[j] = 0; m_src[j] = 0; m_ptr[j] = 0; m_err[j] = 0; m_data[j] = '0;
    end
    @(posedge clk); #1;
    step();
    step();
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_data",  int'(out_data_a),  0);
    chk("rst_err_sel",   int'(err_sel_b),   0);

    // Direct select stepping through every channel
    rst = 1'b0; mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      step();
      chk("dir_out_data", int'(out_data_a), s);
      chk("dir_out_src",  int'(out_src_a),  s);
      chk("dir_out_valid", int'(out_valid_a), 1);
    end
    // sel=3: legal for the 4-channel build, illegal for the 3-channel one
    sel = 2'd3;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bad_sel_in_ready", int'(in_ready_b), 0);
      step();
      chk("dir_out_data3",  int'(out_data_a), 3);
      chk("bad_sel_err",    int'(err_sel_b),  1);
      chk("bad_sel_hold",   int'(out_data_b), 2);
    end
    sel = 2'd0;
    step();
    chk("bad_sel_err_clr", int'(err_sel_b), 0);

    // Round-robin with every channel requesting
    mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rr_all_src", int'(out_src_a), c % 4);
    end

    // Round-robin with channels 1 and 3 requesting, pointer from 0
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 4'b1010;
    step(); chk("rr_1010_a", int'(out_src_a), 1);
    step(); chk("rr_1010_b", int'(out_src_a), 3);
    step(); chk("rr_1010_c", int'(out_src_a), 1);

    // Back-pressure holds the slot
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[15:0] = 16'h00AA;
    step();
    chk("bp_load", int'(out_data_a), 16'h00AA);
    out_ready = 1'b0; in_data[15:0] = 16'h0055;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", int'(in_ready_a), 0);
      step();
      chk("bp_hold", int'(out_data_a), 16'h00AA);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", int'(out_data_a), 16'h0055);

    // Reset while full with a pending request discards the word
    mode = 1'b1; in_valid = 4'b0100; step();
    out_ready = 1'b0; in_valid = 4'b1111; rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready_a), 0);
    step();
    chk("rst_full_valid", int'(out_valid_a), 0);
    chk("rst_full_data",  int'(out_data_a),  0);
    chk("rst_full_src",   int'(out_src_a),   0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("rst_ptr_zero", int'(out_src_a), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(63) == 0);
      if ($urandom_range(31) == 0) mode = ~mode;
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(9) < 7);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
